// File: rtl/sha256_req_arbiter.sv
// Round-robin arbiter sharing one SHA-256 compression core between NUM_REQ requesters.
// The core stays locked to one owner for a whole multi-block message; the final digest returns to that owner.
module sha256_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  input  logic [NUM_REQ*512-1:0] req_block,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   core_start,
  output logic                   core_first,
  output logic [511:0]           core_block,
  input  logic                   core_done,
  input  logic [255:0]           core_digest,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [255:0]           resp_digest,
  output logic                   busy,
  output logic [IDX_W-1:0]       owner
);

  localparam int CW = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    NEXT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner_r;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] sel_idx;
  logic [CW-1:0]    cand;
  logic             win_found;
  logic             first_r;
  logic             last_r;
  logic             take;
  logic [511:0]     sel_block;
  logic [511:0]     core_block_r;
  logic [255:0]     resp_digest_r;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + 1'b1;
  endfunction

  // Cyclic search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        winner    = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    core_start = 1'b0;
    core_first = 1'b0;
    resp_valid = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          req_ready[winner] = 1'b1;
          state_nxt         = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        core_first = first_r;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done) state_nxt = last_r ? RESP : NEXT;
      end
      NEXT: begin
        // Locked: only the current owner may hand over its next block.
        if (req_valid[owner_r]) begin
          req_ready[owner_r] = 1'b1;
          state_nxt          = ISSUE;
        end
      end
      RESP: begin
        resp_valid[owner_r] = 1'b1;
        if (resp_ready[owner_r]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_idx   = (state == IDLE) ? winner : owner_r;
  assign sel_block = req_block[sel_idx*512 +: 512];
  assign take      = |(req_valid & req_ready);

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner_r <= '0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        owner_r <= sel_idx;
        first_r <= (state == IDLE);
        last_r  <= req_last[sel_idx];
      end
      if (state == RESP && resp_ready[owner_r]) begin
        rr_ptr  <= ptr_inc(owner_r);
        owner_r <= '0;
      end
    end
  end

  // Block and digest holding registers; cleared so a reset leaves every output at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_block_r  <= '0;
      resp_digest_r <= '0;
    end else begin
      if (take) core_block_r <= sel_block;
      if (state == WAIT && core_done && last_r) resp_digest_r <= core_digest;
    end
  end

  assign core_block  = core_block_r;
  assign resp_digest = resp_digest_r;
  assign owner       = owner_r;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_sha256_req_arbiter.sv
// Bench for sha256_req_arbiter: per-requester block drivers, a behavioural core, and a grant/response scoreboard.
module tb_sha256_req_arbiter;
  localparam int NR = 4;
  localparam int IW = 2;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] NIST1 = {448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071, 64'h8000000000000000};
  localparam logic [511:0] NIST2 = {448'h0, 64'h1c0};
  localparam logic [255:0] ABC_D  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] NIST_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_last, req_ready, resp_valid, resp_ready;
  logic [NR*512-1:0] req_block;
  logic              core_start, core_first, core_done, busy;
  logic [511:0]      core_block;
  logic [255:0]      core_digest, resp_digest;
  logic [IW-1:0]     owner;

  sha256_req_arbiter #(.NUM_REQ(NR), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_block(req_block),
    .req_ready(req_ready), .core_start(core_start), .core_first(core_first), .core_block(core_block),
    .core_done(core_done), .core_digest(core_digest), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_digest(resp_digest), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [511:0] pend_blk [NR][2];
  int pend_cnt [NR];
  int pend_idx [NR];
  logic hold;
  logic lock_watch, no_resp_watch;
  int lock_viol, no_resp_viol;
  int gq [$];
  logic [NR-1:0] rq_oh [$];
  logic [255:0] rq_dig [$];
  logic core_first_log [$];

  assign resp_ready = hold ? '0 : '1;

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_block = '0;
    for (int i = 0; i < NR; i++) begin
      if (pend_idx[i] < pend_cnt[i]) begin
        req_valid[i] = 1'b1;
        req_last[i]  = (pend_idx[i] == pend_cnt[i] - 1);
        req_block[i*512 +: 512] = pend_blk[i][pend_idx[i][0]];
      end
    end
  end

  function automatic logic [255:0] core_fn(input logic [511:0] b, input logic f);
    if (f && b == ABC_BLK) return ABC_D;
    if (!f && b == NIST2) return NIST_D;
    return b[511:256] ^ b[255:0] ^ {f, 255'h0};
  endfunction

  function automatic logic [511:0] mk_blk(input logic [31:0] n);
    return {32'hC0DE0000 | n, 448'h0, n};
  endfunction

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic set_msg(input int r, input int n, input logic [511:0] b0, input logic [511:0] b1);
    pend_blk[r][0] = b0;
    pend_blk[r][1] = b1;
    pend_idx[r] = 0;
    pend_cnt[r] = n;
  endtask

  task automatic exp_grant(input int r);
    gq.push_back(r);
  endtask

  task automatic exp_resp(input int r, input logic [255:0] d);
    rq_oh.push_back(NR'(1) << r);
    rq_dig.push_back(d);
  endtask

  task automatic wait_resp(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid == '0 && n < 400);
    if (resp_valid == '0) chk(nm, 512'(0), 512'(1));
  endtask

  task automatic drain(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || req_valid != '0) && n < 3000);
    if (busy || req_valid != '0) chk(nm, 512'(busy), 512'(0));
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!core_start && n < 200);
    if (!core_start) chk(nm, 512'(0), 512'(1));
  endtask

  // Requester drivers: a block is consumed on every handshake.
  initial begin
    logic [NR-1:0] hs;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (hs[i]) pend_idx[i]++;
    end
  end

  // Behavioural core: fixed 66-cycle compression latency.
  initial begin
    logic [511:0] blk;
    logic         f;
    forever begin
      @(posedge clk);
      #1;
      if (core_start) begin
        blk = core_block;
        f   = core_first;
        core_first_log.push_back(f);
        repeat (66) @(posedge clk);
        #1;
        core_digest = core_fn(blk, f);
        core_done   = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
      end
    end
  end

  // Monitor: grants and responses against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_onehot", 512'($countones(req_ready) <= 1), 512'(1));
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (gq.size() == 0) chk("grant_unexpected", 512'(i), 512'(99));
          else chk("grant_order", 512'(i), 512'(gq.pop_front()));
        end
      end
      if ((resp_valid & resp_ready) != '0) begin
        if (rq_oh.size() == 0) chk("resp_unexpected", 512'(resp_valid), 512'(0));
        else begin
          chk("resp_owner", 512'(resp_valid), 512'(rq_oh.pop_front()));
          chk("resp_digest", 512'(resp_digest), 512'(rq_dig.pop_front()));
        end
      end
      if (lock_watch && req_ready[0]) lock_viol++;
      if (no_resp_watch && resp_valid != '0) no_resp_viol++;
    end
  end

  initial begin
    logic [NR-1:0] sv;
    logic [255:0]  sd;
    int rr_exp [3];
    int n;
    rr_exp = '{1, 2, 0};
    for (int i = 0; i < NR; i++) begin
      pend_cnt[i] = 0;
      pend_idx[i] = 0;
      pend_blk[i][0] = '0;
      pend_blk[i][1] = '0;
    end
    rst = 1'b1; hold = 1'b0; core_done = 1'b0; core_digest = '0;
    lock_watch = 1'b0; no_resp_watch = 1'b0; lock_viol = 0; no_resp_viol = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 512'({req_ready, core_start, resp_valid, busy, owner}), 512'(0));
    chk("rst_core_block", core_block, 512'(0));
    chk("rst_resp_digest", 512'(resp_digest), 512'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-block "abc" from requester 2
    set_msg(2, 1, ABC_BLK, '0); exp_grant(2); exp_resp(2, ABC_D);
    #1 chk("t1_ready", 512'(req_ready), 512'(4'b0100));
    @(posedge clk);
    #1 chk("t1_start_first", 512'({core_start, core_first}), 512'(2'b11));
    wait_resp("t1_resp_timeout");
    chk("t1_resp_valid", 512'(resp_valid), 512'(4'b0100));
    chk("t1_busy_resp", 512'(busy), 512'(1));
    @(negedge clk);
    chk("t1_busy_after", 512'(busy), 512'(0));

    // Pointer wrap: serve 3, then 3 and 0 together
    @(posedge clk);
    #1;
    set_msg(3, 1, mk_blk(3), '0); exp_grant(3); exp_resp(3, core_fn(mk_blk(3), 1'b1));
    drain("t5_drain_a");
    chk("t5_rr_wrap", 512'(dut.rr_ptr), 512'(0));
    @(posedge clk);
    #1;
    set_msg(3, 1, mk_blk(33), '0); set_msg(0, 1, mk_blk(30), '0);
    exp_grant(0); exp_grant(3);
    exp_resp(0, core_fn(mk_blk(30), 1'b1)); exp_resp(3, core_fn(mk_blk(33), 1'b1));
    #1 chk("t5_ready", 512'(req_ready), 512'(4'b0001));
    drain("t5_drain_b");

    // Simultaneous requests 0, 1, 3
    @(posedge clk);
    #1;
    set_msg(0, 1, mk_blk(40), '0); set_msg(1, 1, mk_blk(41), '0); set_msg(3, 1, mk_blk(43), '0);
    exp_grant(0); exp_grant(1); exp_grant(3);
    exp_resp(0, core_fn(mk_blk(40), 1'b1)); exp_resp(1, core_fn(mk_blk(41), 1'b1));
    exp_resp(3, core_fn(mk_blk(43), 1'b1));
    for (int k = 0; k < 3; k++) begin
      wait_resp("t2_resp_timeout");
      @(negedge clk);
      chk("t2_rr_ptr", 512'(dut.rr_ptr), 512'(rr_exp[k]));
    end
    drain("t2_drain");

    // Two-block message lock on requester 1
    @(posedge clk);
    #1;
    core_first_log.delete();
    set_msg(1, 2, NIST1, NIST2);
    exp_grant(1); exp_grant(1); exp_grant(0);
    exp_resp(1, NIST_D); exp_resp(0, core_fn(mk_blk(50), 1'b1));
    n = 0;
    while (pend_idx[1] < 1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    set_msg(0, 1, mk_blk(50), '0);
    lock_watch = 1'b1;
    wait_resp("t3_resp_timeout");
    chk("t3_resp_owner", 512'(resp_valid), 512'(4'b0010));
    lock_watch = 1'b0;
    drain("t3_drain");
    chk("t3_lock", 512'(lock_viol), 512'(0));
    if (core_first_log.size() < 3) chk("t3_first_count", 512'(core_first_log.size()), 512'(3));
    else chk("t3_first_seq", 512'({core_first_log[0], core_first_log[1], core_first_log[2]}), 512'(3'b101));

    // Response backpressure
    @(posedge clk);
    #1;
    hold = 1'b1;
    set_msg(2, 1, mk_blk(62), '0); set_msg(3, 1, mk_blk(63), '0);
    exp_grant(2); exp_grant(3);
    exp_resp(2, core_fn(mk_blk(62), 1'b1)); exp_resp(3, core_fn(mk_blk(63), 1'b1));
    wait_resp("t4_resp_timeout");
    sv = resp_valid;
    sd = resp_digest;
    chk("t4_resp_owner", 512'(sv), 512'(4'b0100));
    repeat (10) begin
      @(negedge clk);
      chk("t4_stable", 512'({resp_valid, resp_digest, req_ready, core_start}), 512'({sv, sd, 4'b0000, 1'b0}));
    end
    @(posedge clk);
    #1 hold = 1'b0;
    drain("t4_drain");

    // Reset in the middle of WAIT
    @(posedge clk);
    #1;
    set_msg(1, 1, mk_blk(71), '0); exp_grant(1); exp_resp(1, core_fn(mk_blk(71), 1'b1));
    drain("t6_drain_a");
    chk("t6_rr_before", 512'(dut.rr_ptr), 512'(2));
    @(posedge clk);
    #1;
    set_msg(2, 1, mk_blk(72), '0); exp_grant(2);
    wait_start("t6_start_timeout");
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_outputs", 512'({req_ready, core_start, resp_valid, busy, owner}), 512'(0));
    chk("t6_rst_block", core_block, 512'(0));
    chk("t6_rst_state", 512'(dut.state), 512'(0));
    chk("t6_rst_rr", 512'(dut.rr_ptr), 512'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    no_resp_watch = 1'b1;
    repeat (60) @(posedge clk);
    #1 no_resp_watch = 1'b0;
    chk("t6_late_done", 512'(no_resp_viol), 512'(0));
    chk("t6_idle", 512'(busy), 512'(0));
    set_msg(1, 1, mk_blk(81), '0); set_msg(3, 1, mk_blk(83), '0);
    exp_grant(1); exp_grant(3);
    exp_resp(1, core_fn(mk_blk(81), 1'b1)); exp_resp(3, core_fn(mk_blk(83), 1'b1));
    #1 chk("t6_ready_from0", 512'(req_ready), 512'(4'b0010));
    drain("t6_drain_b");

    chk("sb_grants_left", 512'(gq.size()), 512'(0));
    chk("sb_resps_left", 512'(rq_oh.size()), 512'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_req_arbiter.md
Name: sha256_req_arbiter

Overview:
- Shares one SHA-256 compression core between NUM_REQ independent requesters. The core is driven by start/done.
- Accepts 512-bit message blocks from each requester and arbitrates round-robin between them.
- Locks the core to one requester for a whole multi-block message, so chaining is never interleaved.
- Sequences core start/done and returns the final 256-bit digest to the owning requester with a valid/ready handshake.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- IDX_W, 2, owner index width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i presents a block.
- req_last  in  NUM_REQ  the presented block is the last of its message.
- req_block  in  NUM_REQ*512  block data; requester i occupies bits [i*512 +: 512].
- req_ready  out  NUM_REQ  block accepted; the transfer happens when req_valid[i] and req_ready[i] are both high.
- core_start  out  1  one-cycle pulse that launches a compression.
- core_first  out  1  first block of a message: the core loads the IV; when low, the core chains from the prior digest. Valid while core_start is high.
- core_block  out  512  registered block, stable from core_start until core_done.
- core_done  in  1  one-cycle pulse: the compression has finished.
- core_digest  in  256  core hash; valid in the cycle core_done is high.
- resp_valid  out  NUM_REQ  one-hot; the digest is ready for the owner.
- resp_ready  in  NUM_REQ  requester accepts the digest.
- resp_digest  out  256  registered final digest.
- busy  out  1  high in every state except IDLE.
- owner  out  IDX_W  index of the current owner; 0 when IDLE.

Behaviour:
- Reset: asynchronous and active-high.
  - Forces state to IDLE and the round-robin pointer rr_ptr to 0.
  - All outputs are 0: core_block=0, resp_digest=0, owner=0, req_ready=0, core_start=0, resp_valid=0.
  - Reset mid-operation abandons the message silently; core_done pulses arriving after reset are ignored while in IDLE.
- States: IDLE, ISSUE, WAIT, NEXT, RESP. Outputs are decoded from registered state plus inputs.
- IDLE:
  - The winner is the first i with req_valid[i] set, searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, ... mod NUM_REQ).
  - req_ready[winner]=1 combinationally in the same cycle.
  - On that edge: owner<=winner, core_block<=req_block[winner], first_r<=1, last_r<=req_last[winner]; state goes to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE:
  - core_start=1 and core_first=first_r for exactly one cycle, then go to WAIT.
  - The block is accepted at edge T and core_start is high in cycle T+1.
- WAIT:
  - Holds core_block and waits for core_done; core_done is sampled only in WAIT.
  - On core_done with last_r=1: resp_digest<=core_digest, go to RESP.
  - On core_done with last_r=0: go to NEXT.
- NEXT:
  - The owner stays locked.
  - req_ready[owner]=req_valid[owner]; requests from other requesters are not acknowledged.
  - On transfer: core_block<=req_block[owner], first_r<=0, last_r<=req_last[owner], go to ISSUE.
  - Otherwise remain in NEXT indefinitely.
- RESP:
  - resp_valid[owner]=1 and resp_digest is held stable.
  - On resp_ready[owner]: rr_ptr<=owner+1 (wraps from NUM_REQ-1 to 0), owner<=0, go to IDLE.
  - resp_ready on other bits is ignored.
- No combinational path from req_valid to core_start. The minimum gap between a response and the next acceptance is one IDLE cycle.
- req_ready is never high for more than one requester in the same cycle, and is never high in ISSUE, WAIT or RESP.
- A single-block message has req_last=1 on its first block: core_first=1 and a response follows.
- Illegal state encodings recover to IDLE.

Test Plan:
- Single-block message, NUM_REQ=4:
  - Stimulus: requester 2 sends the "abc"-padded block with last=1 at reset-released rr_ptr=0; the core model asserts core_done 66 cycles after start.
  - Required: req_ready[2] in the acceptance cycle; core_start one cycle later with core_first=1.
  - Required: resp_valid=4'b0100 with digest ba7816bf...f20015ad; busy drops the cycle after resp_ready.
- Simultaneous requests:
  - Stimulus: requesters 0, 1 and 3 are all valid with last=1.
  - Required: service order 0, 1, 3; between messages, rr_ptr takes the values 1, 2, 0.
- Two-block message lock:
  - Stimulus: requester 1 sends a two-block message (the 56-byte NIST vector) while requester 0 is held valid.
  - Required: core_first goes 1 then 0; requester 0 sees no req_ready until requester 1's response is accepted.
  - Required: digest 248d6a61...19db06c1.
- Response backpressure:
  - Stimulus: hold resp_ready low for 10 cycles.
  - Required: resp_valid and resp_digest stay stable; no new req_ready; core_start stays low.
- Pointer wrap:
  - Stimulus: requester 3 is served, then requesters 3 and 0 are both valid.
  - Required: requester 0 is granted first.
- Reset mid-WAIT:
  - Stimulus: assert rst 20 cycles after core_start, then release.
  - Required: all outputs 0, state IDLE; a late core_done pulse produces no resp_valid.
  - Required: the next request is granted starting from requester 0.
